// File: rtl/pcgen.sv
// pcgen: fetch-PC generator for the IFU with a boot cycle, halt and prioritised redirects.
// The PC register drives the fetch request directly; pc_nxt exposes the value it loads next edge.
module pcgen #(
    parameter int          XLEN        = 64,
    parameter logic [63:0] RESET_PC    = 64'h8000_0000,
    parameter int          NREDIR      = 3,
    parameter int          INSTR_BYTES = 4,
    localparam int         SRCW        = (NREDIR > 1) ? $clog2(NREDIR) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   halt,
    input  logic [NREDIR-1:0]      redir_valid,
    input  logic [NREDIR*XLEN-1:0] redir_target,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [XLEN-1:0]        req_pc,
    output logic [XLEN-1:0]        pc_nxt,
    output logic                   redir_taken,
    output logic [SRCW-1:0]        redir_src
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            redir_taken_q, redir_taken_d;
    logic [SRCW-1:0] redir_src_q, redir_src_d;

    logic            any_redir;
    logic [SRCW-1:0] sel;
    logic [XLEN-1:0] sel_target;

    // Scan from the lowest-priority source upward so the lowest asserted index wins.
    always_comb begin
        sel        = '0;
        sel_target = '0;
        for (int i = NREDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                sel        = SRCW'(i);
                sel_target = redir_target[i*XLEN +: XLEN];
            end
        end
    end

    assign any_redir = |redir_valid;

    always_comb begin
        state_d       = RUN;
        req_valid     = (state_q == RUN) && !halt && !any_redir;
        pc_d          = pc_q;
        redir_taken_d = any_redir;
        redir_src_d   = redir_src_q;
        if (any_redir) begin
            pc_d        = sel_target;
            redir_src_d = sel;
        end else if (req_valid && req_ready) begin
            pc_d = pc_q + XLEN'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= BOOT;
            pc_q          <= XLEN'(RESET_PC);
            redir_taken_q <= 1'b0;
            redir_src_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redir_taken_q <= redir_taken_d;
            redir_src_q   <= redir_src_d;
        end
    end

    assign req_pc      = pc_q;
    assign pc_nxt      = pc_d;
    assign redir_taken = redir_taken_q;
    assign redir_src   = redir_src_q;

endmodule

// File: tb/tb_pcgen.sv
// tb_pcgen: directed test of pcgen against a behavioural fetch-PC model, plus a 32-bit
// instance used to exercise PC wrap-around at the top of the address space.
module tb_pcgen;

    logic         clk = 1'b0;
    logic         rst;
    logic         halt;
    logic [2:0]   redirValid;
    logic [191:0] redirTarget;
    logic         reqValid;
    logic         reqReady;
    logic [63:0]  reqPc;
    logic [63:0]  pcNxt;
    logic         redirTaken;
    logic [1:0]   redirSrc;

    logic         haltB;
    logic [2:0]   redirValidB;
    logic [95:0]  redirTargetB;
    logic         reqValidB;
    logic         readyB;
    logic [31:0]  reqPcB;
    logic [31:0]  pcNxtB;
    logic         redirTakenB;
    logic [1:0]   redirSrcB;

    int total = 0;
    int bad   = 0;
    logic checkEn = 1'b0;

    // Behavioural model of the architectural fetch state.
    logic        mRun   = 1'b0;
    logic [63:0] mPc    = 64'h8000_0000;
    logic        mTaken = 1'b0;
    logic [1:0]  mSrc   = 2'd0;

    always #5 clk = ~clk;

    pcgen #(.XLEN(64), .RESET_PC(64'h8000_0000), .NREDIR(3), .INSTR_BYTES(4)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .redir_valid(redirValid), .redir_target(redirTarget),
        .req_valid(reqValid), .req_ready(reqReady), .req_pc(reqPc),
        .pc_nxt(pcNxt), .redir_taken(redirTaken), .redir_src(redirSrc)
    );

    pcgen #(.XLEN(32), .RESET_PC(64'h8000_0000), .NREDIR(3), .INSTR_BYTES(4)) dutB (
        .clk(clk), .rst(rst), .halt(haltB),
        .redir_valid(redirValidB), .redir_target(redirTargetB),
        .req_valid(reqValidB), .req_ready(readyB), .req_pc(reqPcB),
        .pc_nxt(pcNxtB), .redir_taken(redirTakenB), .redir_src(redirSrcB)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int firstSrc();
        if (redirValid[0]) return 0;
        if (redirValid[1]) return 1;
        return 2;
    endfunction

    function automatic logic modelValid();
        return mRun && !halt && (redirValid == 3'b000);
    endfunction

    function automatic logic [63:0] modelNext();
        if (redirValid != 3'b000) return redirTarget[firstSrc()*64 +: 64];
        if (modelValid() && reqReady) return mPc + 64'd4;
        return mPc;
    endfunction

    // Model advances on the same edges as the DUT and resets asynchronously with it.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mRun   <= 1'b0;
            mPc    <= 64'h8000_0000;
            mTaken <= 1'b0;
            mSrc   <= 2'd0;
        end else begin
            mPc    <= modelNext();
            mRun   <= 1'b1;
            mTaken <= (redirValid != 3'b000);
            if (redirValid != 3'b000) mSrc <= 2'(firstSrc());
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cyc_req_valid",   reqValid,   modelValid());
            checkOutput("cyc_req_pc",      reqPc,      mPc);
            checkOutput("cyc_pc_nxt",      pcNxt,      modelNext());
            checkOutput("cyc_redir_taken", redirTaken, mTaken);
            checkOutput("cyc_redir_src",   redirSrc,   mSrc);
        end
    end

    task automatic applyStimulus();
        rst = 1'b0; halt = 1'b0; reqReady = 1'b1; redirValid = '0; redirTarget = '0;
        haltB = 1'b0; readyB = 1'b0; redirValidB = '0; redirTargetB = '0;
        checkEn = 1'b1;
        repeat (2) tick();
        checkOutput("rst_req_pc",      reqPc,      64'h8000_0000);
        checkOutput("rst_req_valid",   reqValid,   0);
        checkOutput("rst_pc_nxt",      pcNxt,      64'h8000_0000);
        checkOutput("rst_redir_taken", redirTaken, 0);
        checkOutput("rst_redir_src",   redirSrc,   0);

        rst = 1'b1;
        #1 checkOutput("boot_req_valid", reqValid, 0);
        tick();
        checkOutput("run_pc0",    reqPc,    64'h8000_0000);
        checkOutput("run_valid0", reqValid, 1);
        tick(); checkOutput("seq_pc1", reqPc, 64'h8000_0004);
        tick(); checkOutput("seq_pc2", reqPc, 64'h8000_0008);
        tick(); checkOutput("seq_pc3", reqPc, 64'h8000_000C);
        tick(); checkOutput("seq_pc4", reqPc, 64'h8000_0010);

        reqReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_pc",    reqPc,    64'h8000_0010);
            checkOutput("stall_valid", reqValid, 1);
        end
        reqReady = 1'b1;
        tick(); checkOutput("resume_pc", reqPc, 64'h8000_0014);

        redirValid = 3'b110;
        redirTarget[64 +: 64]  = 64'h1000;
        redirTarget[128 +: 64] = 64'h2000;
        #1;
        checkOutput("redir_kill_valid", reqValid, 0);
        checkOutput("redir_pc_nxt",     pcNxt,    64'h1000);
        tick();
        redirValid = 3'b000;
        #1;
        checkOutput("redir_pc",    reqPc,      64'h1000);
        checkOutput("redir_taken", redirTaken, 1);
        checkOutput("redir_src1",  redirSrc,   1);
        checkOutput("redir_valid", reqValid,   1);
        tick();
        checkOutput("redir_taken_clr", redirTaken, 0);
        checkOutput("redir_seq_pc",    reqPc,      64'h1004);

        halt = 1'b1;
        #1 checkOutput("halt_valid1", reqValid, 0);
        tick();
        redirValid = 3'b001;
        redirTarget[0 +: 64] = 64'h3000;
        tick();
        redirValid = 3'b000;
        #1;
        checkOutput("halt_redir_pc",    reqPc,      64'h3000);
        checkOutput("halt_valid3",      reqValid,   0);
        checkOutput("halt_redir_taken", redirTaken, 1);
        checkOutput("halt_redir_src0",  redirSrc,   0);
        tick();
        checkOutput("halt_valid4", reqValid, 0);
        tick();
        checkOutput("halt_hold_pc", reqPc, 64'h3000);
        halt = 1'b0;
        #1;
        checkOutput("unhalt_valid", reqValid, 1);
        checkOutput("unhalt_pc",    reqPc,    64'h3000);
        tick(); checkOutput("unhalt_seq_pc", reqPc, 64'h3004);

        redirValid = 3'b100;
        redirTarget[128 +: 64] = 64'h4000;
        tick();
        redirValid = 3'b010;
        redirTarget[64 +: 64] = 64'h5000;
        #1;
        checkOutput("b2b_pc1",    reqPc,    64'h4000);
        checkOutput("b2b_valid1", reqValid, 0);
        tick();
        redirValid = 3'b000;
        #1;
        checkOutput("b2b_pc2",    reqPc,      64'h5000);
        checkOutput("b2b_valid2", reqValid,   1);
        checkOutput("b2b_src",    redirSrc,   1);
        checkOutput("b2b_taken",  redirTaken, 1);

        redirValidB = 3'b001;
        redirTargetB[0 +: 32] = 32'hFFFF_FFFC;
        tick();
        redirValidB = 3'b000;
        #1;
        checkOutput("wrap_top_pc", reqPcB,    32'hFFFF_FFFC);
        checkOutput("wrap_valid",  reqValidB, 1);
        readyB = 1'b1;
        #1 checkOutput("wrap_pc_nxt", pcNxtB, 32'h0000_0000);
        tick();
        readyB = 1'b0;
        checkOutput("wrap_pc", reqPcB, 32'h0000_0000);

        redirValid = 3'b001;
        redirTarget[0 +: 64] = 64'h8000_0040;
        tick();
        redirValid = 3'b000;
        reqReady = 1'b0;
        #1;
        checkOutput("pre_rst_pc",    reqPc,    64'h8000_0040);
        checkOutput("pre_rst_valid", reqValid, 1);
        #1 rst = 1'b0;
        #1;
        checkOutput("async_rst_valid", reqValid,   0);
        checkOutput("async_rst_pc",    reqPc,      64'h8000_0000);
        checkOutput("async_rst_nxt",   pcNxt,      64'h8000_0000);
        checkOutput("async_rst_taken", redirTaken, 0);
        checkOutput("async_rst_src",   redirSrc,   0);
        tick();
        rst = 1'b1;
        reqReady = 1'b1;
        #1 checkOutput("reboot_valid0", reqValid, 0);
        tick();
        checkOutput("reboot_pc0",    reqPc,    64'h8000_0000);
        checkOutput("reboot_valid1", reqValid, 1);
        tick(); checkOutput("reboot_pc1", reqPc, 64'h8000_0004);
        repeat (2) tick();
    endtask

    initial begin
        applyStimulus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
